// File: rtl/mem_stage_sram_ctrl_pkg.sv
// Shared widths, defaults, FSM encodings and the SRAM command bundle for the
// MEM-stage SRAM controller.
package mem_stage_sram_ctrl_pkg;

  localparam int DEF_WORD_LEN      = 32;
  localparam int DEF_SRAM_ADDR_LEN = 18;
  localparam int DEF_SRAM_DATA_LEN = 16;
  localparam int DEF_WAIT_CYCLES   = 1;
  localparam int DEF_ADDR_BASE     = 1024;

  // Phase counter width covers the full 0..7 WAIT_CYCLES range.
  localparam int PHASE_CNT_W = 3;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_LO   = 2'd1;
  localparam logic [1:0] ST_HI   = 2'd2;
  localparam logic [1:0] ST_DONE = 2'd3;

  typedef struct packed {
    logic [DEF_SRAM_ADDR_LEN-1:0] addr;
    logic [DEF_SRAM_DATA_LEN-1:0] dq_out;
    logic                         dq_oe;
    logic                         we_n;
    logic                         oe_n;
  } sram_cmd_t;

  localparam sram_cmd_t SRAM_IDLE = '{addr: '0, dq_out: '0, dq_oe: 1'b0,
                                      we_n: 1'b1, oe_n: 1'b1};

endpackage

// File: rtl/mem_stage_sram_ctrl_phase_counter.sv
// Counts 0..MAX_COUNT while enabled and flags the final cycle of an SRAM phase.
module sram_phase_counter
  import mem_stage_sram_ctrl_pkg::*;
#(
  parameter int MAX_COUNT = DEF_WAIT_CYCLES
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clear,
  input  logic en,
  output logic phase_last
);

  logic [PHASE_CNT_W-1:0] cnt_q, cnt_d;

  assign phase_last = (cnt_q == PHASE_CNT_W'(MAX_COUNT));

  always_comb begin
    cnt_d = cnt_q;
    if (clear || (en && phase_last)) begin
      cnt_d = '0;
    end else if (en) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // pre-edge values, independent of block ordering.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/mem_stage_sram_ctrl.sv
// MEM-stage controller: splits a 32-bit load/store into LO then HI 16-bit SRAM
// accesses and holds the pipeline (ready=0) until the word is done.
module mem_stage_sram_ctrl
  import mem_stage_sram_ctrl_pkg::*;
#(
  parameter int WORD_LEN      = DEF_WORD_LEN,
  parameter int SRAM_ADDR_LEN = DEF_SRAM_ADDR_LEN,
  parameter int SRAM_DATA_LEN = DEF_SRAM_DATA_LEN,
  parameter int WAIT_CYCLES   = DEF_WAIT_CYCLES,
  parameter int ADDR_BASE     = DEF_ADDR_BASE
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     MEM_R_EN,
  input  logic                     MEM_W_EN,
  input  logic [WORD_LEN-1:0]      ALURes,
  input  logic [WORD_LEN-1:0]      ST_VAL,
  output logic [WORD_LEN-1:0]      memReadVal,
  output logic                     ready,
  output logic [SRAM_ADDR_LEN-1:0] sram_addr,
  output logic [SRAM_DATA_LEN-1:0] sram_dq_out,
  output logic                     sram_dq_oe,
  input  logic [SRAM_DATA_LEN-1:0] sram_dq_in,
  output logic                     sram_we_n,
  output logic                     sram_oe_n
);

  logic [1:0]          state_q, state_d;
  logic [WORD_LEN-1:0] rd_buf_q, rd_buf_d;
  logic [WORD_LEN-1:0] mem_read_val_q, mem_read_val_d;
  logic                phase_active, phase_last;
  sram_cmd_t           cmd;

  // A simultaneous read and write request is handled as a store.
  logic req, is_store, is_load;
  assign req      = MEM_R_EN | MEM_W_EN;
  assign is_store = MEM_W_EN;
  assign is_load  = MEM_R_EN & ~MEM_W_EN;

  // Byte offset from the SRAM window, wrapped to the half-word-pair range.
  logic [WORD_LEN-1:0]      offset;
  logic [SRAM_ADDR_LEN-2:0] waddr;
  logic                     unused_offset_bits;
  assign offset             = ALURes - WORD_LEN'(ADDR_BASE);
  assign waddr              = offset[SRAM_ADDR_LEN:2];
  assign unused_offset_bits = ^{offset[WORD_LEN-1:SRAM_ADDR_LEN+1], offset[1:0]};

  assign phase_active = (state_q == ST_LO) || (state_q == ST_HI);

  sram_phase_counter #(
    .MAX_COUNT (WAIT_CYCLES)
  ) u_phase_counter (
    .clk        (clk),
    .rst_n      (rst),
    .clear      (~phase_active),
    .en         (phase_active),
    .phase_last (phase_last)
  );

  // NOTE: every variable written here gets a default first, so no path through
  // the case statement can leave one unassigned and infer a latch.
  always_comb begin
    state_d        = state_q;
    rd_buf_d       = rd_buf_q;
    mem_read_val_d = mem_read_val_q;
    cmd            = SRAM_IDLE;
    ready          = 1'b0;

    if (phase_active) begin
      cmd.addr  = {waddr, (state_q == ST_HI)};
      cmd.we_n  = ~is_store;
      cmd.oe_n  = ~is_load;
      cmd.dq_oe = is_store;
      if (is_store) begin
        cmd.dq_out = (state_q == ST_HI) ? ST_VAL[WORD_LEN-1:SRAM_DATA_LEN]
                                        : ST_VAL[SRAM_DATA_LEN-1:0];
      end
    end

    case (state_q)
      ST_IDLE: begin
        ready = ~req;
        if (req) state_d = ST_LO;
      end
      ST_LO: begin
        if (phase_last) begin
          if (is_load) rd_buf_d[SRAM_DATA_LEN-1:0] = sram_dq_in;
          state_d = ST_HI;
        end
      end
      ST_HI: begin
        if (phase_last) begin
          // Commit on entry to DONE so memReadVal is valid for the whole DONE cycle.
          if (is_load) begin
            rd_buf_d[WORD_LEN-1:SRAM_DATA_LEN] = sram_dq_in;
            mem_read_val_d                     = rd_buf_d;
          end
          state_d = ST_DONE;
        end
      end
      default: begin
        ready   = 1'b1;
        state_d = ST_IDLE;
      end
    endcase
  end

  // NOTE: the read buffer is reset along with memReadVal, so an aborted load
  // leaves no stale half-word behind.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q        <= ST_IDLE;
      rd_buf_q       <= '0;
      mem_read_val_q <= '0;
    end else begin
      state_q        <= state_d;
      rd_buf_q       <= rd_buf_d;
      mem_read_val_q <= mem_read_val_d;
    end
  end

  assign memReadVal  = mem_read_val_q;
  assign sram_addr   = cmd.addr;
  assign sram_dq_out = cmd.dq_out;
  assign sram_dq_oe  = cmd.dq_oe;
  assign sram_we_n   = cmd.we_n;
  assign sram_oe_n   = cmd.oe_n;

endmodule
